// File: rtl/pipe_stage_ctrl.sv
// Pipeline control for NUM_STAGES stage registers: valid tracking, load/bubble strobes and a
// run/halt/single-step debug FSM. Optional performance counters are enabled by PIPE_PERF_EN.
module pipe_stage_ctrl #(
  parameter int unsigned NUM_STAGES = 5,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  debug_en,
  input  logic                  debug_step,
  input  logic                  fetch_valid,
  input  logic [NUM_STAGES-1:0] stall_req,
  input  logic [NUM_STAGES-1:0] flush_req,
  output logic [NUM_STAGES-1:0] stg_en,
  output logic [NUM_STAGES-1:0] stg_rst,
  output logic [NUM_STAGES-1:0] stg_valid,
  output logic                  retire,
  output logic                  halted
`ifdef PIPE_PERF_EN
  ,
  output logic [CNT_W-1:0]      perf_stall,
  output logic [CNT_W-1:0]      perf_flush,
  output logic [CNT_W-1:0]      perf_retire
`endif
);

  typedef enum logic [1:0] {StRun, StHalt, StStep} state_e;

  state_e                  state_q, state_d;
  logic                    step_q;
  logic                    step_rise;
  logic                    go;
  logic [NUM_STAGES-1:0]   valid_q, valid_d;
  logic [NUM_STAGES-1:0]   hold, kill;
  logic [NUM_STAGES-1:0]   en_raw, rst_raw;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StRun;
      step_q  <= 1'b0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= debug_step;
      valid_q <= valid_d;
    end
  end

  assign step_rise = debug_step & ~step_q;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun:   if (debug_en) state_d = StHalt;
      StHalt: begin
        if (!debug_en)     state_d = StRun;
        else if (step_rise) state_d = StStep;
      end
      StStep:  state_d = debug_en ? StHalt : StRun;
      default: state_d = StRun;
    endcase
  end

  // FSM outputs
  always_comb begin
    go     = (state_q == StRun) || (state_q == StStep);
    halted = (state_q == StHalt);
  end

  // Walk from oldest to youngest so stalls and qualified flushes accumulate downward.
  always_comb begin
    logic stall_acc;
    logic flush_acc;
    stall_acc = 1'b0;
    flush_acc = 1'b0;
    hold      = '0;
    kill      = '0;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      stall_acc = stall_acc | stall_req[i];
      hold[i]   = ~go | stall_acc;
      kill[i]   = flush_acc;
      flush_acc = flush_acc | (flush_req[i] & valid_q[i] & ~hold[i]);
    end
  end

  always_comb begin
    en_raw  = '0;
    rst_raw = '0;
    valid_d = valid_q;
    for (int i = 0; i < NUM_STAGES; i++) begin
      rst_raw[i] = kill[i];
      if (i > 0) rst_raw[i] = rst_raw[i] | (hold[i-1] & ~hold[i]);
      en_raw[i] = go & (~hold[i] | kill[i]);
      if (en_raw[i] && rst_raw[i]) valid_d[i] = 1'b0;
      else if (hold[i])            valid_d[i] = valid_q[i];
      else if (i == 0)             valid_d[i] = fetch_valid;
      else                         valid_d[i] = valid_q[i-1];
    end
  end

  // Reset forces the datapath strobes directly, without waiting for a clock.
  always_comb begin
    stg_en    = rst ? '0 : en_raw;
    stg_rst   = rst ? '1 : rst_raw;
    retire    = ~rst & valid_q[NUM_STAGES-1] & ~hold[NUM_STAGES-1];
    stg_valid = valid_q;
  end

`ifdef PIPE_PERF_EN
  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q, retire_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
      retire_cnt_q <= '0;
    end else if (!halted) begin
      if (go && (|stall_req) && !(&stall_cnt_q)) stall_cnt_q <= stall_cnt_q + CntOne;
      if ((|kill) && !(&flush_cnt_q))            flush_cnt_q <= flush_cnt_q + CntOne;
      if (retire && !(&retire_cnt_q))            retire_cnt_q <= retire_cnt_q + CntOne;
    end
  end

  assign perf_stall  = stall_cnt_q;
  assign perf_flush  = flush_cnt_q;
  assign perf_retire = retire_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_ctrl.sv
// Directed bench for pipe_stage_ctrl (NUM_STAGES=5): free run, stall, flush, stall+flush,
// debug halt/step/resume and asynchronous reset mid-run.
module tb_pipe_stage_ctrl;

  localparam int unsigned N = 5;
  localparam int unsigned W = 32;

  logic         clk;
  logic         rst;
  logic         debug_en;
  logic         debug_step;
  logic         fetch_valid;
  logic [N-1:0] stall_req;
  logic [N-1:0] flush_req;
  logic [N-1:0] stg_en;
  logic [N-1:0] stg_rst;
  logic [N-1:0] stg_valid;
  logic         retire;
  logic         halted;
`ifdef PIPE_PERF_EN
  logic [W-1:0] perf_stall, perf_flush, perf_retire;
`endif

  int checks = 0;
  int errors = 0;

  pipe_stage_ctrl #(.NUM_STAGES(N), .CNT_W(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .debug_en    (debug_en),
    .debug_step  (debug_step),
    .fetch_valid (fetch_valid),
    .stall_req   (stall_req),
    .flush_req   (flush_req),
    .stg_en      (stg_en),
    .stg_rst     (stg_rst),
    .stg_valid   (stg_valid),
    .retire      (retire),
    .halted      (halted)
`ifdef PIPE_PERF_EN
    ,
    .perf_stall  (perf_stall),
    .perf_flush  (perf_flush),
    .perf_retire (perf_retire)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; checks follow 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [N-1:0] exp_v;
    rst = 1'b1; debug_en = 1'b0; debug_step = 1'b0; fetch_valid = 1'b0;
    stall_req = '0; flush_req = '0;
    #2;
    chk("rst_valid", 32'(stg_valid), 32'h00);
    chk("rst_en", 32'(stg_en), 32'h00);
    chk("rst_stgrst", 32'(stg_rst), 32'h1f);
    chk("rst_retire", 32'(retire), 32'h0);
    chk("rst_halted", 32'(halted), 32'h0);

    // Free run
    tick(); rst = 1'b0; fetch_valid = 1'b1; #1;
    chk("run_en", 32'(stg_en), 32'h1f);
    chk("run_stgrst", 32'(stg_rst), 32'h00);
    for (int k = 1; k <= 5; k++) begin
      tick(); #1;
      exp_v = N'((1 << k) - 1);
      chk("fill_valid", 32'(stg_valid), 32'(exp_v));
      chk("fill_retire", 32'(retire), (k == 5) ? 32'h1 : 32'h0);
    end
    tick(); #1;
    chk("full_retire", 32'(retire), 32'h1);
    chk("full_en", 32'(stg_en), 32'h1f);

    // Stall in stage 2 for two cycles
    stall_req = 5'b00100; #1;
    chk("stall1_en", 32'(stg_en), 32'h18);
    chk("stall1_stgrst", 32'(stg_rst), 32'h08);
    tick(); #1;
    chk("stall2_en", 32'(stg_en), 32'h18);
    chk("stall2_stgrst", 32'(stg_rst), 32'h08);
    chk("stall2_valid", 32'(stg_valid), 32'h17);
    tick(); stall_req = '0; #1;
    chk("stall_after_valid", 32'(stg_valid), 32'h07);
    chk("stall_after_stgrst", 32'(stg_rst), 32'h00);
`ifdef PIPE_PERF_EN
    chk("perf_stall", perf_stall, 32'd2);
`endif
    tick(); tick(); #1;
    chk("refill1_valid", 32'(stg_valid), 32'h1f);

    // Flush from stage 2
    flush_req = 5'b00100; #1;
    chk("flush_stgrst", 32'(stg_rst), 32'h03);
    chk("flush_en", 32'(stg_en), 32'h1f);
    tick(); flush_req = '0; #1;
    chk("flush_valid", 32'(stg_valid), 32'h1c);
`ifdef PIPE_PERF_EN
    chk("perf_flush", perf_flush, 32'd1);
`endif
    for (int k = 0; k < 5; k++) tick();
    #1;
    chk("refill2_valid", 32'(stg_valid), 32'h1f);

    // Flush in stage 3 while stage 4 stalls
    flush_req = 5'b01000; stall_req = 5'b10000; #1;
    for (int k = 0; k < 3; k++) begin
      chk("sf_hold_en", 32'(stg_en), 32'h00);
      chk("sf_hold_stgrst", 32'(stg_rst), 32'h00);
      tick(); #1;
    end
    chk("sf_hold_valid", 32'(stg_valid), 32'h1f);
    stall_req = '0; #1;
    chk("sf_rel_stgrst", 32'(stg_rst), 32'h07);
    chk("sf_rel_en", 32'(stg_en), 32'h1f);
    tick(); flush_req = '0; #1;
    chk("sf_post_stgrst", 32'(stg_rst), 32'h00);
    chk("sf_post_valid", 32'(stg_valid), 32'h18);
    for (int k = 0; k < 5; k++) tick();
    #1;
    chk("refill3_valid", 32'(stg_valid), 32'h1f);

    // Debug halt: the sampling cycle still advances
    debug_en = 1'b1; #1;
    chk("dbg_req_en", 32'(stg_en), 32'h1f);
    chk("dbg_req_halted", 32'(halted), 32'h0);
    tick(); #1;
    chk("dbg_halted", 32'(halted), 32'h1);
    chk("dbg_halt_en", 32'(stg_en), 32'h00);
    chk("dbg_halt_valid", 32'(stg_valid), 32'h1f);

    // First step
    debug_step = 1'b1; fetch_valid = 1'b0; #1;
    chk("step1_pre_en", 32'(stg_en), 32'h00);
    tick(); #1;
    chk("step1_en", 32'(stg_en), 32'h1f);
    debug_step = 1'b0;
    tick(); #1;
    chk("step1_valid", 32'(stg_valid), 32'h1e);
    chk("step1_halted", 32'(halted), 32'h1);
    chk("step1_post_en", 32'(stg_en), 32'h00);

    // Second step
    debug_step = 1'b1;
    tick(); #1;
    chk("step2_en", 32'(stg_en), 32'h1f);
    debug_step = 1'b0;
    tick(); #1;
    chk("step2_valid", 32'(stg_valid), 32'h1c);
    tick(); #1;
    chk("step2_hold_valid", 32'(stg_valid), 32'h1c);

    // Resume
    debug_en = 1'b0; fetch_valid = 1'b1; #1;
    chk("resume_pre_en", 32'(stg_en), 32'h00);
    tick(); #1;
    chk("resume_halted", 32'(halted), 32'h0);
    chk("resume_en", 32'(stg_en), 32'h1f);
    for (int k = 0; k < 5; k++) tick();
    #1;
    chk("refill4_valid", 32'(stg_valid), 32'h1f);

    // Asynchronous reset away from the clock edge
    #2; rst = 1'b1; #1;
    chk("arst_valid", 32'(stg_valid), 32'h00);
    chk("arst_halted", 32'(halted), 32'h0);
    chk("arst_en", 32'(stg_en), 32'h00);
    chk("arst_stgrst", 32'(stg_rst), 32'h1f);
    chk("arst_retire", 32'(retire), 32'h0);
`ifdef PIPE_PERF_EN
    chk("arst_perf_stall", perf_stall, 32'd0);
    chk("arst_perf_flush", perf_flush, 32'd0);
    chk("arst_perf_retire", perf_retire, 32'd0);
`endif
    tick(); rst = 1'b0;
    tick(); #1;
    chk("post_arst_valid", 32'(stg_valid), 32'h01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_stage_ctrl.md
Name: pipe_stage_ctrl

Overview:
- Parametrised pipeline-control unit for the MIPS core family. It generalises the fixed five-stage if/id/exe/mem/wb rst/en/valid signalling to NUM_STAGES stages.
- It tracks a valid bit per pipeline register and derives per-stage load-enable and bubble-insert strobes from stall requests, flush requests and fetch validity.
- It includes a run/halt/single-step debug FSM.
- It sits between the controller's hazard logic and the datapath's stage registers.

Parameters:
- NUM_STAGES, 5, number of pipeline registers (>=2); index 0 = youngest (IF), NUM_STAGES-1 = oldest (WB).
- CNT_W, 32, width of performance counters (only used with PIPE_PERF_EN).

Ports:
- clk  in  1  main clock
- rst  in  1  reset, asynchronous, active-high
- debug_en  in  1  debug mode request
- debug_step  in  1  step request; level signal, edge-detected internally
- fetch_valid  in  1  instruction presented to register 0 is valid
- stall_req  in  NUM_STAGES  stall_req[i]: stage i cannot advance this cycle
- flush_req  in  NUM_STAGES  flush_req[i]: stage i squashes all younger stages (index < i)
- stg_en  out  NUM_STAGES  register i loads this cycle
- stg_rst  out  NUM_STAGES  register i loads a bubble this cycle (synchronous clear into datapath)
- stg_valid  out  NUM_STAGES  register i holds a valid instruction
- retire  out  1  oldest stage valid and advancing this cycle
- halted  out  1  FSM in HALT
- perf_stall  out  CNT_W  (PIPE_PERF_EN only) stall-cycle count
- perf_flush  out  CNT_W  (PIPE_PERF_EN only) flush-event count
- perf_retire  out  CNT_W  (PIPE_PERF_EN only) retired-instruction count

Behaviour:
- One clock, clk. Asynchronous active-high reset, rst. rst asserted forces outputs immediately:
  - stg_valid=0, FSM=RUN, step edge register=0, counters=0.
  - stg_en=0, stg_rst=all ones, retire=0, halted=0.
- FSM states RUN, HALT, STEP; go = (state==RUN)|(state==STEP).
  - RUN -> HALT when debug_en=1. The cycle in which debug_en is first sampled still advances.
  - HALT -> RUN when debug_en=0.
  - HALT -> STEP on a debug_step rising edge (debug_step & ~step_q) with debug_en=1.
  - STEP lasts exactly one cycle, then goes to HALT if debug_en=1, else RUN.
  - A step cycle is consumed even if stalled.
- hold[i] = ~go | OR(stall_req[NUM_STAGES-1:i]). A stall holds its own stage and all younger stages.
- kill[i] = OR over j>i of (flush_req[j] & stg_valid[j] & ~hold[j]).
  - A flush takes effect only when the flushing stage advances, so it fires exactly once per instruction.
  - Flush requests from invalid stages are ignored.
- stg_rst[i] = kill[i] | (i>0 & hold[i-1] & ~hold[i]).
- stg_en[i] = go & (~hold[i] | kill[i]). A kill overrides a hold of the younger stage.
- Next stg_valid[i], first match wins:
  1. rst -> 0
  2. stg_en[i]&stg_rst[i] -> 0
  3. hold[i] -> keep
  4. i==0 -> fetch_valid
  5. otherwise -> stg_valid[i-1]
- retire = stg_valid[NUM_STAGES-1] & ~hold[NUM_STAGES-1].
- stg_en, stg_rst and retire are combinational from state and inputs, with no added latency. stg_valid, state and halted are registered.
- Simultaneous flush_req from several stages: the oldest qualified one dominates by the OR; the result is identical.
- Simultaneous stall and flush in the same stage: the flush is ignored until the stall drops.

Optional Feature:
- Macro PIPE_PERF_EN.
- Defined: three CNT_W saturating counters, cleared by rst, frozen while halted.
  - perf_stall increments on cycles with go=1 and any stall_req bit set.
  - perf_flush increments on cycles with any kill bit set.
  - perf_retire increments on retire.
- Undefined: perf_* ports and counters are absent; all other behaviour is identical.

Test Plan:
- Free run, NUM_STAGES=5, fetch_valid=1, no stalls/flushes:
  - stg_valid = 00001, 00011, ... 11111 after 5 cycles.
  - stg_en=11111, stg_rst=00000.
  - retire=1 every cycle from cycle 5.
- Pipe full, stall_req[2]=1 for 2 cycles:
  - stg_en=11000 and stg_rst=01000 in both cycles.
  - stg_valid[3]=0 after, stg_valid[2:0] retained.
  - perf_stall=2 with PIPE_PERF_EN.
- Pipe full, flush_req[2]=1 for 1 cycle:
  - stg_rst=00011, stg_en=11111.
  - Next cycle stg_valid=11100.
  - perf_flush=1.
- Pipe full, flush_req[3]=1 and stall_req[4]=1 together for 3 cycles, then stall drops:
  - No kill while stalled.
  - On release stg_rst=00111 for exactly one cycle.
- Pipe full, rst pulsed mid-run (not clock-aligned): stg_valid=00000 immediately, halted=0, counters 0.
- debug_en=1:
  - halted=1 next cycle, stg_en=00000.
  - Two debug_step pulses give exactly two single-cycle advances (stg_valid shifts twice).
  - debug_en=0 resumes RUN with halted=0 the next cycle.
